// File: rtl/bcd_seg_scan.sv
// Multiplexed 7-segment driver for packed BCD words, with frame-aligned updates
// and optional leading-zero blanking.
module bcd_seg_scan #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  bcd_valid,
  input  logic                  blank_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] pend;
  logic                pend_flag;
  logic                tick;
  logic                boundary;
  logic [DIGITS-1:0]   zero_up;
  logic [DIGITS-1:0]   an_next;
  logic [3:0]          digit;
  logic                blank;
  logic [6:0]          seg_next;

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // zero_up[k]: digit k and every more significant digit are zero
  always_comb begin
    zero_up = '0;
    zero_up[DIGITS-1] = (disp[4*DIGITS-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--)
      zero_up[k] = zero_up[k+1] && (disp[4*k +: 4] == 4'd0);
  end

  always_comb begin
    an_next = '0;
    digit   = '0;
    blank   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        an_next[k] = 1'b1;
        digit      = disp[4*k +: 4];
        blank      = blank_en && (k != 0) && zero_up[k];
      end
    end
    seg_next = blank ? 7'h00 : decode(digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      pend       <= '0;
      pend_flag  <= 1'b0;
      an         <= '0;
      seg        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      frame_done <= boundary;
      // a strobe landing on the boundary goes straight to the display
      if (boundary) begin
        if (bcd_valid)
          disp <= bcd_in;
        else if (pend_flag)
          disp <= pend;
        pend_flag <= 1'b0;
      end else if (bcd_valid) begin
        pend      <= bcd_in;
        pend_flag <= 1'b1;
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end
endmodule
